traffic_light_ctrl: RTL and testbench

//  Parametrised two-road (NS/EW) traffic-light controller for the DE-board LED bank.
//  - Phase timing comes from an internal tick prescaler and per-phase tick counters.
//  - Adds an all-red clearance phase between directions.
//  - Adds latched pedestrian requests that end a green early.
//  - Adds a night flashing mode.

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/tick_gen.sv | 29 ++
 rtl/traffic_light_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic-light controller:
// state codes, LED bank bit positions and the fixed LED patterns.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam int LED_NS_G = 0;
    localparam int LED_NS_Y = 1;
    localparam int LED_NS_R = 2;
    localparam int LED_EW_G = 3;
    localparam int LED_EW_Y = 4;
    localparam int LED_EW_R = 5;

    localparam logic [5:0] LED_ALLRED    = 6'((1 << LED_NS_R) | (1 << LED_EW_R));
    localparam logic [5:0] LED_NS_GREEN  = 6'((1 << LED_NS_G) | (1 << LED_EW_R));
    localparam logic [5:0] LED_NS_YELLOW = 6'((1 << LED_NS_Y) | (1 << LED_EW_R));
    localparam logic [5:0] LED_EW_GREEN  = 6'((1 << LED_EW_G) | (1 << LED_NS_R));
    localparam logic [5:0] LED_EW_YELLOW = 6'((1 << LED_EW_Y) | (1 << LED_NS_R));

    // Night-mode pattern: NS yellow and EW red blink together.
    function automatic logic [5:0] flash_led(input logic phase);
        logic [5:0] pattern;
        pattern           = '0;
        pattern[LED_NS_Y] = phase;
        pattern[LED_EW_R] = phase;
        return pattern;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: free-running counter that emits a one-cycle tick
// every TICK_DIV clocks, on the cycle where the count is TICK_DIV-1.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Count 0..TICK_DIV-1 and wrap; only reset clears the count.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road (NS/EW) traffic-light controller with all-red clearance,
// latched pedestrian requests that shorten the opposing green, and a
// night flashing mode. All outputs are registered alongside the state.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_T     = 8,
    parameter int MIN_GREEN_T = 3,
    parameter int YELLOW_T    = 2,
    parameter int ALLRED_T    = 1,
    parameter int FLASH_T     = 1
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       night_mode,
    output logic [5:0] LED,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] state_o
);

    localparam int MAX_T = max_of(max_of(GREEN_T, YELLOW_T), max_of(ALLRED_T, FLASH_T));
    localparam int TW    = $clog2(MAX_T) + 1;

    state_t        state;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          tick;
    logic          ped_ns;
    logic          ped_ew;
    logic          flash_phase;

    logic allred_done;
    logic green_done;
    logic min_green_done;
    logic yellow_done;
    logic flash_done;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .tick     (tick)
    );

    // The comparisons use the count including the current tick, so a
    // phase of duration D ends on the D-th tick after entry.
    assign timer_next     = timer + TW'(1);
    assign allred_done    = (timer_next >= TW'(ALLRED_T));
    assign green_done     = (timer_next >= TW'(GREEN_T));
    assign min_green_done = (timer_next >= TW'(MIN_GREEN_T));
    assign yellow_done    = (timer_next >= TW'(YELLOW_T));
    assign flash_done     = (timer_next >= TW'(FLASH_T));

    assign state_o = state;

    // Controller FSM: state, phase timer, ped latches and registered LED/walk outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state       <= ALLRED_A;
            timer       <= '0;
            ped_ns      <= 1'b0;
            ped_ew      <= 1'b0;
            flash_phase <= 1'b0;
            LED         <= LED_ALLRED;
            walk_ns     <= 1'b0;
            walk_ew     <= 1'b0;
        end else begin
            ped_ns <= ped_ns | ped_req_ns;
            ped_ew <= ped_ew | ped_req_ew;

            case (state)
                ALLRED_A: begin
                    if (tick) begin
                        if (allred_done) begin
                            timer <= '0;
                            if (night_mode) begin
                                state       <= FLASH;
                                LED         <= flash_led(1'b1);
                                flash_phase <= 1'b1;
                            end else begin
                                state   <= NS_GREEN;
                                LED     <= LED_NS_GREEN;
                                walk_ns <= ped_ns;
                                ped_ns  <= ped_req_ns;
                            end
                        end else begin
                            timer <= timer_next;
                        end
                    end
                end

                NS_GREEN: begin
                    if (tick) begin
                        if (green_done || (ped_ew && min_green_done)) begin
                            timer   <= '0;
                            state   <= NS_YELLOW;
                            LED     <= LED_NS_YELLOW;
                            walk_ns <= 1'b0;
                        end else begin
                            timer <= timer_next;
                        end
                    end
                end

                NS_YELLOW: begin
                    if (tick) begin
                        if (yellow_done) begin
                            timer <= '0;
                            state <= ALLRED_B;
                            LED   <= LED_ALLRED;
                        end else begin
                            timer <= timer_next;
                        end
                    end
                end

                ALLRED_B: begin
                    if (tick) begin
                        if (allred_done) begin
                            timer <= '0;
                            if (night_mode) begin
                                state       <= FLASH;
                                LED         <= flash_led(1'b1);
                                flash_phase <= 1'b1;
                            end else begin
                                state   <= EW_GREEN;
                                LED     <= LED_EW_GREEN;
                                walk_ew <= ped_ew;
                                ped_ew  <= ped_req_ew;
                            end
                        end else begin
                            timer <= timer_next;
                        end
                    end
                end

                EW_GREEN: begin
                    if (tick) begin
                        if (green_done || (ped_ns && min_green_done)) begin
                            timer   <= '0;
                            state   <= EW_YELLOW;
                            LED     <= LED_EW_YELLOW;
                            walk_ew <= 1'b0;
                        end else begin
                            timer <= timer_next;
                        end
                    end
                end

                EW_YELLOW: begin
                    if (tick) begin
                        if (yellow_done) begin
                            timer <= '0;
                            state <= ALLRED_A;
                            LED   <= LED_ALLRED;
                        end else begin
                            timer <= timer_next;
                        end
                    end
                end

                FLASH: begin
                    if (tick) begin
                        if (!night_mode) begin
                            timer       <= '0;
                            state       <= ALLRED_A;
                            LED         <= LED_ALLRED;
                            flash_phase <= 1'b0;
                        end else if (flash_done) begin
                            timer       <= '0;
                            flash_phase <= ~flash_phase;
                            LED         <= flash_led(~flash_phase);
                        end else begin
                            timer <= timer_next;
                        end
                    end
                end

                default: begin
                    state       <= ALLRED_A;
                    timer       <= '0;
                    flash_phase <= 1'b0;
                    LED         <= LED_ALLRED;
                    walk_ns     <= 1'b0;
                    walk_ew     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: a phase-level reference
// model compared every cycle, directed scenarios with literal
// expectations, then randomized ped/night/reset traffic.
module tb_traffic_light_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int GREEN_T     = 8;
    localparam int MIN_GREEN_T = 3;
    localparam int YELLOW_T    = 2;
    localparam int ALLRED_T    = 1;
    localparam int FLASH_T     = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       night_mode;
    logic [5:0] led;
    logic       walk_ns;
    logic       walk_ew;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase index 0..5 walks the normal cycle, 6 is flashing.
    int         m_phase = 0;
    int         m_ticks = 0;
    int         m_presc = 0;
    bit         m_ped_ns = 0;
    bit         m_ped_ew = 0;
    bit         m_walk_ns = 0;
    bit         m_walk_ew = 0;
    bit         m_flash = 0;
    bit         model_valid = 0;
    bit         skip_cmp = 0;
    bit         illegal_pending = 0;
    int         dur_tab [6] = '{ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T};
    logic [5:0] led_tab [6] = '{6'b100100, 6'b100001, 6'b100010, 6'b100100, 6'b001100, 6'b010100};

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .GREEN_T     (GREEN_T),
        .MIN_GREEN_T (MIN_GREEN_T),
        .YELLOW_T    (YELLOW_T),
        .ALLRED_T    (ALLRED_T),
        .FLASH_T     (FLASH_T)
    ) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .ped_req_ns (ped_req_ns),
        .ped_req_ew (ped_req_ew),
        .night_mode (night_mode),
        .LED        (led),
        .walk_ns    (walk_ns),
        .walk_ew    (walk_ew),
        .state_o    (state_o)
    );

    task automatic applyStimulus(input logic r, input logic pn, input logic pe, input logic nm);
        rst        = r;
        ped_req_ns = pn;
        ped_req_ew = pe;
        night_mode = nm;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitState(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state_o !== s) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: timeout waiting for state %0d, state_o=%0d", name, s, state_o);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic modelStep();
        bit tick;
        bit old_ns;
        bit old_ew;
        bit waiting;
        int next;
        if (rst) begin
            m_phase = 0; m_ticks = 0; m_presc = 0;
            m_ped_ns = 0; m_ped_ew = 0; m_walk_ns = 0; m_walk_ew = 0; m_flash = 0;
            model_valid = 1;
            return;
        end
        if (!model_valid) return;
        tick     = (m_presc == TICK_DIV - 1);
        m_presc  = (m_presc + 1) % TICK_DIV;
        old_ns   = m_ped_ns;
        old_ew   = m_ped_ew;
        m_ped_ns = m_ped_ns | ped_req_ns;
        m_ped_ew = m_ped_ew | ped_req_ew;
        if (illegal_pending) begin
            m_phase = 0; m_ticks = 0; m_walk_ns = 0; m_walk_ew = 0; m_flash = 0;
            illegal_pending = 0;
            skip_cmp = 0;
            return;
        end
        if (!tick) return;
        m_ticks++;
        next = -1;
        if (m_phase == 6) begin
            if (!night_mode) next = 0;
            else if (m_ticks >= FLASH_T) begin
                m_flash = !m_flash;
                m_ticks = 0;
            end
        end else begin
            waiting = (m_phase == 1) ? old_ew : (m_phase == 4) ? old_ns : 1'b0;
            if (m_ticks >= dur_tab[m_phase] || (waiting && m_ticks >= MIN_GREEN_T)) begin
                if ((m_phase == 0 || m_phase == 3) && night_mode) next = 6;
                else next = (m_phase + 1) % 6;
            end
        end
        if (next >= 0) begin
            m_ticks   = 0;
            m_walk_ns = 0;
            m_walk_ew = 0;
            if (next == 1) begin m_walk_ns = old_ns; m_ped_ns = ped_req_ns; end
            if (next == 4) begin m_walk_ew = old_ew; m_ped_ew = ped_req_ew; end
            if (next == 6) m_flash = 1;
            m_phase = next;
        end
    endtask

    function automatic logic [5:0] expLed();
        if (m_phase == 6) return {m_flash, 3'b000, m_flash, 1'b0};
        return led_tab[m_phase];
    endfunction

    // Model update on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid && !skip_cmp) begin
                checkOutput("model_led", {2'b00, led}, {2'b00, expLed()});
                checkOutput("model_walk_ns", {7'b0, walk_ns}, {7'b0, m_walk_ns});
                checkOutput("model_walk_ew", {7'b0, walk_ew}, {7'b0, m_walk_ew});
                checkOutput("model_state", {5'b0, state_o}, 8'(m_phase));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int         k;
        int         t1_edge [9] = '{3, 4, 35, 36, 44, 48, 80, 88, 92};
        logic [5:0] t1_led  [9] = '{6'b100100, 6'b100001, 6'b100001, 6'b100010, 6'b100100,
                                    6'b001100, 6'b010100, 6'b100100, 6'b100001};
        applyStimulus(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset_led", {2'b00, led}, 8'b00100100);
        checkOutput("reset_state", {5'b0, state_o}, 8'd0);

        $display("[TB] scenario 1: free-running cycle");
        applyStimulus(0, 0, 0, 0);
        k = 0;
        for (int c = 1; c <= 92; c++) begin
            @(negedge clk);
            if (c == t1_edge[k]) begin
                checkOutput($sformatf("t1_led_edge%0d", c), {2'b00, led}, {2'b00, t1_led[k]});
                k++;
            end
        end

        $display("[TB] scenario 2: EW ped pulse at NS green tick 1");
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        waitState(3'd1, 20, "t2_wait_ns_green");
        repeat (3) @(negedge clk);
        applyStimulus(0, 0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        repeat (7) @(negedge clk);
        checkOutput("t2_still_green", {5'b0, state_o}, 8'd1);
        @(negedge clk);
        checkOutput("t2_early_yellow", {5'b0, state_o}, 8'd2);
        waitState(3'd4, 40, "t2_wait_ew_green");
        checkOutput("t2_walk_ew", {7'b0, walk_ew}, 8'd1);

        $display("[TB] scenario 3: NS ped held high");
        applyStimulus(0, 1, 0, 0);
        waitState(3'd1, 200, "t3_wait_ns_green");
        checkOutput("t3_walk_ns", {7'b0, walk_ns}, 8'd1);
        waitState(3'd3, 200, "t3_wait_allred_b");
        waitState(3'd4, 100, "t3_wait_ew_green");
        repeat (11) @(negedge clk);
        checkOutput("t3_ew_tick2", {5'b0, state_o}, 8'd4);
        @(negedge clk);
        checkOutput("t3_ew_short", {5'b0, state_o}, 8'd5);

        $display("[TB] scenario 4: night mode");
        applyStimulus(0, 0, 0, 0);
        waitState(3'd3, 200, "t4_wait_allred_b");
        waitState(3'd4, 100, "t4_wait_ew_green");
        applyStimulus(0, 0, 0, 1);
        waitState(3'd6, 200, "t4_wait_flash");
        checkOutput("t4_flash_on", {2'b00, led}, 8'b00100010);
        repeat (4) @(negedge clk);
        checkOutput("t4_flash_off", {2'b00, led}, 8'b00000000);
        repeat (4) @(negedge clk);
        checkOutput("t4_flash_on2", {2'b00, led}, 8'b00100010);
        applyStimulus(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("t4_flash_hold", {5'b0, state_o}, 8'd6);
        @(negedge clk);
        checkOutput("t4_flash_exit", {5'b0, state_o}, 8'd0);

        $display("[TB] scenario 5: reset in NS yellow");
        waitState(3'd2, 200, "t5_wait_ns_yellow");
        @(negedge clk);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5_led", {2'b00, led}, 8'b00100100);
        checkOutput("t5_walk", {6'b0, walk_ns, walk_ew}, 8'd0);
        checkOutput("t5_state", {5'b0, state_o}, 8'd0);
        repeat (3) @(negedge clk);
        checkOutput("t5_allred_hold", {5'b0, state_o}, 8'd0);
        @(negedge clk);
        checkOutput("t5_ns_green", {5'b0, state_o}, 8'd1);

        $display("[TB] scenario 6: illegal state code");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        skip_cmp        = 1;
        illegal_pending = 1;
        force dut.state = traffic_pkg::state_t'(3'd7);
        #1;
        release dut.state;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_state", {5'b0, state_o}, 8'd0);
        checkOutput("t6_led", {2'b00, led}, 8'b00100100);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            applyStimulus(($urandom_range(0, 999) == 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 399) == 0) ? !night_mode : night_mode);
        end
        applyStimulus(0, 0, 0, 0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
